// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : risc_controller
//  Description : Phase sequencer and control-strobe decoder for a simple
//                8-instruction accumulator CPU. A 3-bit phase register steps
//                through the eight phases of every instruction. The strobes
//                are decoded combinationally from phase, opcode, zero and the
//                halted flag, so they change in the same cycle as their
//                inputs.
//  Ports       : clk    in   1  clock, rising-edge active
//                rst    in   1  synchronous active-high reset
//                opcode in   3  instruction opcode (HLT..JMP = 0..7)
//                zero   in   1  accumulator-is-zero flag
//                phase  out  3  current phase register value
//                sel    out  1  address mux select (1 = PC, 0 = IR operand)
//                rd     out  1  memory read strobe
//                ld_ir  out  1  instruction register load
//                inc_pc out  1  program counter increment
//                ld_pc  out  1  program counter load (jump)
//                ld_ac  out  1  accumulator load
//                wr     out  1  memory write strobe
//                data_e out  1  data bus driver enable
//                halt   out  1  processor halted
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt
);

  // Instruction opcodes
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Instruction phases
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t phase_q;
  logic   halted_q;
  logic   aluop;

  // ---------------------------------------------------------------------------
  // Phase sequencer. The phase advances unconditionally while running; opcode
  // only matters when HLT is seen in OP_ADDR. That edge still advances the
  // phase to OP_FETCH, where it then stays frozen until reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      phase_q <= phase_t'(phase_q + 3'd1);
      if (phase_q == OP_ADDR && opcode == OP_HLT) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Instructions that read a memory operand into the accumulator.
  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  assign phase = phase_q;
  assign halt  = halted_q;

  // ---------------------------------------------------------------------------
  // Strobe decode. While halted, every strobe is forced low whatever the phase,
  // opcode and zero flag are.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (!halted_q) begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          // SKZ and JMP are different opcodes, so inc_pc and ld_pc are
          // mutually exclusive here.
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          // wr and data_e share one term, so a write always has the bus driven.
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_controller
//  Description : Directed, self-checking bench for risc_controller. Each
//                scenario task drives opcode and zero and compares every
//                output against hand-computed per-phase expectations. A
//                monitor checks the strobe invariants on every cycle.
//                Expected strobe vectors are packed as
//                {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int n_cmp;
  int n_fail;

  logic [8:0] outs;
  assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  risc_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants, checked every cycle once reset has been applied.
  logic mon_en;
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp = n_cmp + 2;
      if (inc_pc === 1'b1 && ld_pc === 1'b1) begin
        n_fail = n_fail + 1;
        $display("FAIL inv_inc_ld: inc_pc=%b ld_pc=%b at phase %0d, required not both 1", inc_pc, ld_pc, phase);
      end
      if (wr === 1'b1 && data_e !== 1'b1) begin
        n_fail = n_fail + 1;
        $display("FAIL inv_wr_de: wr=%b data_e=%b at phase %0d, required data_e=1 when wr=1", wr, data_e, phase);
      end
    end
  end

  // Watchdog: the run is far shorter than this bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Leaves the time just after the reset edge, with phase 0 showing.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    opcode = 3'd2;
    zero   = 1'b1;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp = n_cmp + 2;
    if (phase !== 3'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_phase: got %0d, required 0", phase);
    end
    if (outs !== 9'b100000000) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outs: got %b, required %b", outs, 9'b100000000);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    opcode = 3'd2;
    zero   = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp = n_cmp + 2;
      if (phase !== 3'(i)) begin
        n_fail = n_fail + 1;
        $display("FAIL add_phase[%0d]: got %0d, required %0d", i, phase, i);
      end
      if (outs !== exp[i]) begin
        n_fail = n_fail + 1;
        $display("FAIL add_outs[%0d]: got %b, required %b", i, outs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (phase !== 3'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL add_wrap: got %0d, required 0", phase);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_skz();
    logic [8:0] exp [8];
    for (int z = 1; z >= 0; z--) begin
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
      if (z == 1) exp[6] = 9'b000100000;
      opcode = 3'd1;
      zero   = z[0];
      do_reset();
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        n_cmp = n_cmp + 2;
        if (phase !== 3'(i)) begin
          n_fail = n_fail + 1;
          $display("FAIL skz_z%0d_phase[%0d]: got %0d, required %0d", z, i, phase, i);
        end
        if (outs !== exp[i]) begin
          n_fail = n_fail + 1;
          $display("FAIL skz_z%0d_outs[%0d]: got %b, required %b", z, i, outs, exp[i]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_jmp();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000};
    opcode = 3'd7;
    zero   = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp = n_cmp + 2;
      if (phase !== 3'(i)) begin
        n_fail = n_fail + 1;
        $display("FAIL jmp_phase[%0d]: got %0d, required %0d", i, phase, i);
      end
      if (outs !== exp[i]) begin
        n_fail = n_fail + 1;
        $display("FAIL jmp_outs[%0d]: got %b, required %b", i, outs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sto();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    opcode = 3'd6;
    zero   = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp = n_cmp + 2;
      if (phase !== 3'(i)) begin
        n_fail = n_fail + 1;
        $display("FAIL sto_phase[%0d]: got %0d, required %0d", i, phase, i);
      end
      if (outs !== exp[i]) begin
        n_fail = n_fail + 1;
        $display("FAIL sto_outs[%0d]: got %b, required %b", i, outs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    logic [8:0] exp [5];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000, 9'b000100000};
    opcode = 3'd0;
    zero   = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp = n_cmp + 2;
      if (phase !== 3'(i)) begin
        n_fail = n_fail + 1;
        $display("FAIL hlt_phase[%0d]: got %0d, required %0d", i, phase, i);
      end
      if (outs !== exp[i]) begin
        n_fail = n_fail + 1;
        $display("FAIL hlt_outs[%0d]: got %b, required %b", i, outs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
    // Halted: opcode and zero wander but nothing may move.
    for (int c = 0; c < 12; c++) begin
      opcode = 3'(c);
      zero   = c[0];
      @(negedge clk);
      n_cmp = n_cmp + 2;
      if (phase !== 3'd5) begin
        n_fail = n_fail + 1;
        $display("FAIL halted_phase[%0d]: got %0d, required 5", c, phase);
      end
      if (outs !== 9'b000000001) begin
        n_fail = n_fail + 1;
        $display("FAIL halted_outs[%0d]: got %b, required %b", c, outs, 9'b000000001);
      end
      @(posedge clk);
      #1;
    end
    opcode = 3'd2;
    do_reset();
    @(negedge clk);
    n_cmp = n_cmp + 2;
    if (phase !== 3'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL unhalt_phase: got %0d, required 0", phase);
    end
    if (outs !== 9'b100000000) begin
      n_fail = n_fail + 1;
      $display("FAIL unhalt_outs: got %b, required %b", outs, 9'b100000000);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (phase !== 3'd1) begin
      n_fail = n_fail + 1;
      $display("FAIL unhalt_advance: got %0d, required 1", phase);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    opcode = 3'd6;
    zero   = 1'b0;
    do_reset();
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp = n_cmp + 2;
    if (phase !== 3'd6) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_pre_phase: got %0d, required 6", phase);
    end
    if (data_e !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_pre_data_e: got %b, required 1", data_e);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp = n_cmp + 2;
      if (phase !== 3'(i)) begin
        n_fail = n_fail + 1;
        $display("FAIL mid_phase[%0d]: got %0d, required %0d", i, phase, i);
      end
      if (outs !== exp[i]) begin
        n_fail = n_fail + 1;
        $display("FAIL mid_outs[%0d]: got %b, required %b", i, outs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    mon_en = 1'b0;
    rst    = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    #2;
    test_reset();
    test_add();
    test_skz();
    test_jmp();
    test_sto();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
